// File: rtl/gcd_operand_sequencer.sv
// Feeds operand pairs from a small FIFO into the GCD datapath/controller pair
// and hands each result (or a timeout error) to a downstream consumer.
// Operands of zero bypass the core entirely; a hung core is aborted after
// TIMEOUT wait cycles.
module gcd_operand_sequencer #(
  parameter int WIDTH         = 16,
  parameter int DEPTH         = 2,
  parameter int LOAD_A_CYCLES = 2,
  parameter int TIMEOUT       = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             core_start,
  output logic [WIDTH-1:0] core_data_in,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_aout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_err,
  output logic             busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int LW = (LOAD_A_CYCLES > 1) ? $clog2(LOAD_A_CYCLES + 1) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD_A = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [2*WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]      wr_ptr_r;
  logic [PW-1:0]      rd_ptr_r;
  logic [CW-1:0]      count_r;
  logic               full_s;
  logic               empty_s;
  logic               push_s;
  logic               pop_s;
  logic [WIDTH-1:0]   head_a_s;
  logic [WIDTH-1:0]   head_b_s;

  // Sequencer state and next-state values
  state_t             state_r;
  state_t             state_nx_s;
  logic [LW-1:0]      load_cnt_r;
  logic [LW-1:0]      load_cnt_nx_s;
  logic [TW-1:0]      to_cnt_r;
  logic [TW-1:0]      to_cnt_nx_s;
  logic [WIDTH-1:0]   op_b_r;
  logic [WIDTH-1:0]   op_b_nx_s;
  logic               start_nx_s;
  logic [WIDTH-1:0]   data_nx_s;
  logic               valid_nx_s;
  logic [WIDTH-1:0]   rdata_nx_s;
  logic               rerr_nx_s;
  logic               zero_s;
  logic               load_last_s;
  logic               to_last_s;
  logic               hs_s;

  assign full_s      = (count_r == CW'(DEPTH));
  assign empty_s     = (count_r == CW'(0));
  assign in_ready    = !full_s;
  assign push_s      = in_valid && !full_s;
  assign pop_s       = (state_r == ST_IDLE) && !empty_s;
  assign head_a_s    = mem_r[rd_ptr_r][2*WIDTH-1:WIDTH];
  assign head_b_s    = mem_r[rd_ptr_r][WIDTH-1:0];
  assign zero_s      = (head_a_s == {WIDTH{1'b0}}) || (head_b_s == {WIDTH{1'b0}});
  assign load_last_s = (load_cnt_r == LW'(LOAD_A_CYCLES - 1));
  assign to_last_s   = (to_cnt_r == TW'(TIMEOUT - 1));
  assign hs_s        = res_valid && res_ready;
  assign busy        = (state_r != ST_IDLE) || !empty_s;

  // Operand pair storage; contents are don't-care until the pointers say otherwise
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {in_a, in_b};
    end
  end

  // FIFO pointers wrap naturally (power-of-two depth); count separates full from empty
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= CW'(0);
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nx_s;
  end

  // Next-state decode; done takes priority over the timeout in WAIT
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) state_nx_s = zero_s ? ST_RESP : ST_LOAD_A;
        else          state_nx_s = ST_IDLE;
      end
      ST_LOAD_A: begin
        if (load_last_s) state_nx_s = ST_WAIT;
        else             state_nx_s = ST_LOAD_A;
      end
      ST_WAIT: begin
        if (core_done || to_last_s) state_nx_s = ST_RESP;
        else                        state_nx_s = ST_WAIT;
      end
      ST_RESP: begin
        if (hs_s) state_nx_s = ST_IDLE;
        else      state_nx_s = ST_RESP;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Next values for the registered outputs and counters
  always_comb begin
    start_nx_s    = 1'b0;
    data_nx_s     = core_data_in;
    valid_nx_s    = 1'b0;
    rdata_nx_s    = res_data;
    rerr_nx_s     = res_err;
    load_cnt_nx_s = LW'(0);
    to_cnt_nx_s   = TW'(0);
    op_b_nx_s     = op_b_r;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          op_b_nx_s = head_b_s;
          if (zero_s) begin
            rdata_nx_s = head_a_s | head_b_s;
            rerr_nx_s  = 1'b0;
          end else begin
            start_nx_s = 1'b1;
            data_nx_s  = head_a_s;
          end
        end else begin
          op_b_nx_s = op_b_r;
        end
      end
      ST_LOAD_A: begin
        if (load_last_s) data_nx_s     = op_b_r;
        else             load_cnt_nx_s = load_cnt_r + LW'(1);
      end
      ST_WAIT: begin
        if (core_done) begin
          rdata_nx_s = core_aout;
          rerr_nx_s  = 1'b0;
        end else if (to_last_s) begin
          rdata_nx_s = {WIDTH{1'b0}};
          rerr_nx_s  = 1'b1;
        end else begin
          to_cnt_nx_s = to_cnt_r + TW'(1);
        end
      end
      ST_RESP: begin
        valid_nx_s = !hs_s;
      end
      default: begin
        valid_nx_s = 1'b0;
      end
    endcase
  end

  // Output and counter registers; res_valid rises the cycle after RESP is entered
  always_ff @(posedge clk) begin
    if (rst) begin
      core_start   <= 1'b0;
      core_data_in <= {WIDTH{1'b0}};
      res_valid    <= 1'b0;
      res_data     <= {WIDTH{1'b0}};
      res_err      <= 1'b0;
      load_cnt_r   <= LW'(0);
      to_cnt_r     <= TW'(0);
      op_b_r       <= {WIDTH{1'b0}};
    end else begin
      core_start   <= start_nx_s;
      core_data_in <= data_nx_s;
      res_valid    <= valid_nx_s;
      res_data     <= rdata_nx_s;
      res_err      <= rerr_nx_s;
      load_cnt_r   <= load_cnt_nx_s;
      to_cnt_r     <= to_cnt_nx_s;
      op_b_r       <= op_b_nx_s;
    end
  end

endmodule
